// File: rtl/tl_tx_fc_arb.sv
// rtl/tl_tx_fc_arb.sv - flow-control-gated round-robin TLP transmit arbiter
//
// Picks one of NUM_CH header/payload FIFO pairs when the channel has header and
// data credit and the retry buffer can hold the whole packet, then streams a
// header beat followed by ceil(len/(DATA_W/32)) payload beats.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   hdr_valid_i/len_i/data_i        per-channel header FIFO head
//   hdr_rden_o                      per-channel header FIFO pop
//   data_i, data_rden_o             per-channel payload FIFO head and pop
//   cl_load_i, cl_hdr_i, cl_data_i  InitFC credit limits (0 = infinite)
//   fc_upd_i, fc_hdr_i, fc_data_i   UpdateFC absolute credit limits
//   retry_free_i                    free retry-buffer beats
//   link_active_i                   DL_Up
//   tlp_*                           outgoing beat stream
//   credit_stall_o                  registered: channel waiting on credit
module tl_tx_fc_arb #(
    parameter int NUM_CH  = 3,
    parameter int DATA_W  = 256,
    parameter int CRED_W  = 12,
    parameter int RETRY_W = 11,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        hdr_valid_i,
    input  logic [NUM_CH*10-1:0]     hdr_len_i,
    input  logic [NUM_CH*128-1:0]    hdr_data_i,
    output logic [NUM_CH-1:0]        hdr_rden_o,
    input  logic [NUM_CH*DATA_W-1:0] data_i,
    output logic [NUM_CH-1:0]        data_rden_o,
    input  logic [NUM_CH-1:0]        cl_load_i,
    input  logic [NUM_CH*CRED_W-1:0] cl_hdr_i,
    input  logic [NUM_CH*CRED_W-1:0] cl_data_i,
    input  logic [NUM_CH-1:0]        fc_upd_i,
    input  logic [NUM_CH*CRED_W-1:0] fc_hdr_i,
    input  logic [NUM_CH*CRED_W-1:0] fc_data_i,
    input  logic [RETRY_W-1:0]       retry_free_i,
    input  logic                     link_active_i,
    input  logic                     tlp_ready_i,
    output logic [DATA_W-1:0]        tlp_o,
    output logic                     tlp_valid_o,
    output logic                     tlp_sop_o,
    output logic                     tlp_eop_o,
    output logic [CH_W-1:0]          tlp_ch_o,
    output logic [NUM_CH-1:0]        credit_stall_o
);

    localparam int DW_PER_BEAT = DATA_W / 32;
    localparam logic [CRED_W-1:0] HALF = {1'b1, {(CRED_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    state_t state, state_nxt;

    logic [CRED_W-1:0] hdr_limit  [NUM_CH];
    logic [CRED_W-1:0] data_limit [NUM_CH];
    logic [CRED_W-1:0] hdr_cons   [NUM_CH];
    logic [CRED_W-1:0] data_cons  [NUM_CH];
    logic [NUM_CH-1:0] hdr_inf, data_inf;

    logic [CH_W-1:0]   ch_q, last_grant;
    logic [10:0]       beats_q;

    logic [10:0]       beats_c [NUM_CH];
    logic [CRED_W-1:0] dneed_c [NUM_CH];
    logic [NUM_CH-1:0] hdr_ok, data_ok, eligible, stall_c;

    logic              grant_found;
    logic [CH_W-1:0]   grant_ch;
    logic [10:0]       grant_beats;

    logic [127:0]      hdr_sel;
    logic [DATA_W-1:0] data_sel;

    // Wrap-safe window test: remaining room, read modulo 2^CRED_W, must sit in
    // the lower half of the counter space.
    function automatic logic cred_ok(input logic inf,
                                     input logic [CRED_W-1:0] limit,
                                     input logic [CRED_W-1:0] cons,
                                     input logic [CRED_W-1:0] need);
        logic [CRED_W-1:0] room;
        room = limit - (cons + need);
        return inf | (room <= HALF);
    endfunction

    always_comb begin
        logic [10:0] len_ext;
        len_ext = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            len_ext    = {1'b0, hdr_len_i[i*10 +: 10]};
            beats_c[i] = (len_ext + 11'(DW_PER_BEAT - 1)) / 11'(DW_PER_BEAT);
            dneed_c[i] = CRED_W'((len_ext + 11'd3) >> 2);
            hdr_ok[i]  = cred_ok(hdr_inf[i], hdr_limit[i], hdr_cons[i], CRED_W'(1));
            data_ok[i] = (len_ext == 11'd0) |
                         cred_ok(data_inf[i], data_limit[i], data_cons[i], dneed_c[i]);
            // Whole packet (header + payload beats) must fit in the retry buffer.
            eligible[i] = hdr_valid_i[i] & link_active_i & hdr_ok[i] & data_ok[i] &
                          (({21'd0, beats_c[i]} + 32'd1) <= 32'(retry_free_i));
            stall_c[i]  = hdr_valid_i[i] & link_active_i & ~(hdr_ok[i] & data_ok[i]);
        end
    end

    // Round robin: lowest eligible index above last_grant, else wrap to the
    // lowest eligible index overall.
    always_comb begin
        grant_found = 1'b0;
        grant_ch    = '0;
        grant_beats = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (eligible[i] && (i > int'(last_grant))) begin
                grant_found = 1'b1;
                grant_ch    = CH_W'(i);
                grant_beats = beats_c[i];
            end
        end
        if (!grant_found) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (eligible[i]) begin
                    grant_found = 1'b1;
                    grant_ch    = CH_W'(i);
                    grant_beats = beats_c[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (grant_found) state_nxt = HDR;
            HDR:  if (tlp_ready_i) state_nxt = (beats_q != 11'd0) ? DATA : IDLE;
            DATA: if (tlp_ready_i && beats_q == 11'd1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        hdr_sel  = '0;
        data_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_q == CH_W'(i)) begin
                hdr_sel  = hdr_data_i[i*128 +: 128];
                data_sel = data_i[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        tlp_o       = '0;
        tlp_valid_o = 1'b0;
        tlp_sop_o   = 1'b0;
        tlp_eop_o   = 1'b0;
        hdr_rden_o  = '0;
        data_rden_o = '0;
        tlp_ch_o    = ch_q;
        case (state)
            HDR: begin
                tlp_valid_o   = 1'b1;
                tlp_sop_o     = 1'b1;
                tlp_eop_o     = (beats_q == 11'd0);
                tlp_o[127:0]  = hdr_sel;
                for (int i = 0; i < NUM_CH; i++)
                    hdr_rden_o[i] = tlp_ready_i && (ch_q == CH_W'(i));
            end
            DATA: begin
                tlp_valid_o = 1'b1;
                tlp_eop_o   = (beats_q == 11'd1);
                tlp_o       = data_sel;
                for (int i = 0; i < NUM_CH; i++)
                    data_rden_o[i] = tlp_ready_i && (ch_q == CH_W'(i));
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q           <= '0;
            beats_q        <= '0;
            last_grant     <= CH_W'(NUM_CH - 1);
            credit_stall_o <= '0;
            hdr_inf        <= '0;
            data_inf       <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                hdr_limit[i]  <= '0;
                data_limit[i] <= '0;
                hdr_cons[i]   <= '0;
                data_cons[i]  <= '0;
            end
        end else begin
            credit_stall_o <= stall_c;

            if (state == IDLE && grant_found) begin
                ch_q       <= grant_ch;
                beats_q    <= grant_beats;
                last_grant <= grant_ch;
            end else if (state == DATA && tlp_ready_i) begin
                beats_q <= beats_q - 11'd1;
            end

            for (int i = 0; i < NUM_CH; i++) begin
                if (state == IDLE && !link_active_i) begin
                    // Link down between packets: forget all negotiated credit.
                    hdr_limit[i]  <= '0;
                    data_limit[i] <= '0;
                    hdr_cons[i]   <= '0;
                    data_cons[i]  <= '0;
                    hdr_inf[i]    <= 1'b0;
                    data_inf[i]   <= 1'b0;
                end else if (cl_load_i[i]) begin
                    hdr_limit[i]  <= cl_hdr_i[i*CRED_W +: CRED_W];
                    data_limit[i] <= cl_data_i[i*CRED_W +: CRED_W];
                    hdr_inf[i]    <= (cl_hdr_i[i*CRED_W +: CRED_W] == '0);
                    data_inf[i]   <= (cl_data_i[i*CRED_W +: CRED_W] == '0);
                    hdr_cons[i]   <= '0;
                    data_cons[i]  <= '0;
                end else begin
                    if (fc_upd_i[i] && !hdr_inf[i])
                        hdr_limit[i] <= fc_hdr_i[i*CRED_W +: CRED_W];
                    if (fc_upd_i[i] && !data_inf[i])
                        data_limit[i] <= fc_data_i[i*CRED_W +: CRED_W];
                    if (state == IDLE && grant_found && grant_ch == CH_W'(i)) begin
                        hdr_cons[i]  <= hdr_cons[i] + CRED_W'(1);
                        data_cons[i] <= data_cons[i] + dneed_c[i];
                    end
                end
            end
        end
    end

endmodule
